// File: rtl/instr_register_pkg.sv
// ----------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its write-side arbiter:
//   DEPTH         - number of instruction register slots (32)
//   opcode_t      - 4-bit instruction opcode
//   operand_t     - 32-bit signed operand
//   address_t     - slot index, wide enough for DEPTH
//   instruction_t - one register entry (opcode + two operands)
//   arb_state_t   - ownership FSM states of instr_write_arbiter
//   next_ptr()    - slot pointer increment with wrap at DEPTH-1
// ----------------------------------------------------------------------------
package instr_register_pkg;

    localparam int DEPTH = 32;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef logic [$clog2(DEPTH)-1:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Explicit wrap so the pointer stays correct should DEPTH stop being a
    // power of two.
    function automatic address_t next_ptr(input address_t p);
        return (p == address_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage : instr_register_pkg

// File: rtl/instr_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// instr_write_arbiter_if
// Bundles the two requester handshakes and the instruction register write
// bus of instr_write_arbiter.
//   req0_* / req1_*      - valid, opcode, operand_a, operand_b, ready
//   load_en              - one-cycle write strobe to the instruction register
//   write_index          - target slot of the write
//   opcode/operand_a/_b  - write data
// Modports:
//   slave  - the arbiter: takes requests, returns ready, drives the write bus
//   master - the environment: issues requests, observes ready and write bus
// ----------------------------------------------------------------------------
interface instr_write_arbiter_if;
    import instr_register_pkg::*;

    logic     req0_valid;
    opcode_t  req0_opcode;
    operand_t req0_operand_a;
    operand_t req0_operand_b;
    logic     req0_ready;

    logic     req1_valid;
    opcode_t  req1_opcode;
    operand_t req1_operand_a;
    operand_t req1_operand_b;
    logic     req1_ready;

    logic     load_en;
    address_t write_index;
    opcode_t  opcode;
    operand_t operand_a;
    operand_t operand_b;

    modport slave (
        input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        output req0_ready, req1_ready,
        output load_en, write_index, opcode, operand_a, operand_b
    );

    modport master (
        output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
        output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
        input  req0_ready, req1_ready,
        input  load_en, write_index, opcode, operand_a, operand_b
    );

endinterface : instr_write_arbiter_if

// File: rtl/instr_write_arbiter.sv
// ----------------------------------------------------------------------------
// instr_write_arbiter
// Arbitrates two write requesters onto one instruction register write port.
// A three-state ownership FSM (IDLE/OWN0/OWN1) grants one requester at a
// time; the owner keeps the port for up to MAX_BURST consecutive writes while
// the other requester waits, then ownership passes over without a bubble.
// Ties from IDLE go to the requester not served last.
//
// Parameters:
//   MAX_BURST   - max consecutive accepted writes per owner while the other
//                 requester is waiting (default 4)
// Ports:
//   clk         - rising-edge clock
//   reset_en    - synchronous active-low reset
//   wr_ptr_clr  - returns the write pointer to slot 0 on the next edge
//   bus         - requester handshakes and register write bus (slave side)
//   last_grant  - index of the most recently granted requester
//   grant_cnt0/grant_cnt1 - saturating per-requester transfer counts,
//                 present only when IWA_STATS_EN is defined
//
// Timing: a transfer accepted at an edge appears on load_en/write_index/
// opcode/operands right after that edge (one-cycle latency). Write data holds
// its last value between transfers.
// ----------------------------------------------------------------------------
module instr_write_arbiter
    import instr_register_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset_en,
    input  logic                  wr_ptr_clr,
    instr_write_arbiter_if.slave  bus,
    output logic                  last_grant
`ifdef IWA_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    typedef logic [BURST_W-1:0] burst_t;

    arb_state_t   state;
    address_t     wr_ptr;
    burst_t       burst_cnt;
    logic         load_en_q;
    address_t     write_index_q;
    instruction_t data_q;

    instruction_t req0_instr;
    instruction_t req1_instr;
    logic         xfer0;
    logic         xfer1;
    logic         xfer;
    logic         burst_done;

    assign req0_instr = '{opc: bus.req0_opcode, op_a: bus.req0_operand_a,
                          op_b: bus.req0_operand_b};
    assign req1_instr = '{opc: bus.req1_opcode, op_a: bus.req1_operand_a,
                          op_b: bus.req1_operand_b};

    // Ready is a pure decode of the state register, so it is low in IDLE and
    // the IDLE-to-owner step always costs one bubble cycle.
    assign bus.req0_ready = (state == OWN0);
    assign bus.req1_ready = (state == OWN1);

    assign xfer0 = (state == OWN0) && bus.req0_valid;
    assign xfer1 = (state == OWN1) && bus.req1_valid;
    assign xfer  = xfer0 || xfer1;

    // True on the transfer that brings the owner's count up to MAX_BURST.
    assign burst_done = (burst_cnt == burst_t'(MAX_BURST - 1));

    assign bus.load_en     = load_en_q;
    assign bus.write_index = write_index_q;
    assign bus.opcode      = data_q.opc;
    assign bus.operand_a   = data_q.op_a;
    assign bus.operand_b   = data_q.op_b;

    // NOTE: reset is sampled on the clock edge only, so every register here
    // sits in the synchronous reset branch; there is no asynchronous path.
    always_ff @(posedge clk) begin
        if (!reset_en) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            burst_cnt     <= '0;
            load_en_q     <= 1'b0;
            write_index_q <= '0;
            data_q        <= '{opc: ZERO, op_a: '0, op_b: '0};
            last_grant    <= 1'b1;
        end else begin
            // Strobe is recomputed every cycle, so it can never stretch.
            load_en_q <= xfer;

            if (xfer) begin
                write_index_q <= wr_ptr;
                data_q        <= xfer1 ? req1_instr : req0_instr;
            end

            // A clear coinciding with a transfer still lets that transfer use
            // the old pointer (captured above); only the pointer itself resets.
            if (wr_ptr_clr) begin
                wr_ptr <= '0;
            end else if (xfer) begin
                wr_ptr <= next_ptr(wr_ptr);
            end

            unique case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (bus.req0_valid && bus.req1_valid) begin
                        if (last_grant) begin
                            state      <= OWN0;
                            last_grant <= 1'b0;
                        end else begin
                            state      <= OWN1;
                            last_grant <= 1'b1;
                        end
                    end else if (bus.req0_valid) begin
                        state      <= OWN0;
                        last_grant <= 1'b0;
                    end else if (bus.req1_valid) begin
                        state      <= OWN1;
                        last_grant <= 1'b1;
                    end
                end

                OWN0: begin
                    if (!bus.req0_valid) begin
                        burst_cnt <= '0;
                        if (bus.req1_valid) begin
                            state      <= OWN1;
                            last_grant <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (burst_done) begin
                        // Burst exhausted: hand over if anyone waits,
                        // otherwise keep ownership with a fresh count.
                        burst_cnt <= '0;
                        if (bus.req1_valid) begin
                            state      <= OWN1;
                            last_grant <= 1'b1;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end

                OWN1: begin
                    if (!bus.req1_valid) begin
                        burst_cnt <= '0;
                        if (bus.req0_valid) begin
                            state      <= OWN0;
                            last_grant <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (burst_done) begin
                        burst_cnt <= '0;
                        if (bus.req0_valid) begin
                            state      <= OWN0;
                            last_grant <= 1'b0;
                        end
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef IWA_STATS_EN
    // Per-requester accepted-transfer counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_en) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (xfer0 && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (xfer1 && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule : instr_write_arbiter

// File: tb/tb_instr_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_instr_write_arbiter
// Directed self-checking bench for instr_write_arbiter (MAX_BURST = 4).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. they show the effect of the edge just passed.
// Define IWA_STATS_EN to also cover the grant counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_write_arbiter;
    import instr_register_pkg::*;

    logic clk;
    logic reset_en;
    logic wr_ptr_clr;
    logic last_grant;
`ifdef IWA_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    instr_write_arbiter_if bus ();

    instr_write_arbiter #(.MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_en   (reset_en),
        .wr_ptr_clr (wr_ptr_clr),
        .bus        (bus),
        .last_grant (last_grant)
`ifdef IWA_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_en = 1'b0;
        step();
        reset_en = 1'b1;
    endtask

    initial begin
        reset_en           = 1'b0;
        wr_ptr_clr         = 1'b0;
        bus.req0_valid     = 1'b0;
        bus.req0_opcode    = ZERO;
        bus.req0_operand_a = '0;
        bus.req0_operand_b = '0;
        bus.req1_valid     = 1'b0;
        bus.req1_opcode    = ZERO;
        bus.req1_operand_a = '0;
        bus.req1_operand_b = '0;

        // ---------------- reset values ----------------
        step();
        step();
        check("rst_load_en",   bus.load_en, 0);
        check("rst_index",     bus.write_index, 0);
        check("rst_opcode",    bus.opcode, ZERO);
        check("rst_operand_a", bus.operand_a, 0);
        check("rst_operand_b", bus.operand_b, 0);
        check("rst_last_grant", last_grant, 1);
        check("rst_ready0",    bus.req0_ready, 0);
        check("rst_ready1",    bus.req1_ready, 0);

        // ---------------- single requester, 3 writes ----------------
        reset_en           = 1'b1;
        bus.req0_valid     = 1'b1;
        bus.req0_opcode    = ADD;
        bus.req0_operand_a = 32'sd5;
        bus.req0_operand_b = 32'sd7;
        step();
        check("t1_bubble_load", bus.load_en, 0);
        check("t1_ready0",      bus.req0_ready, 1);
        check("t1_last_grant",  last_grant, 0);
        for (int j = 0; j < 3; j++) begin
            step();
            check("t1_load",   bus.load_en, 1);
            check("t1_index",  bus.write_index, 64'(j));
            check("t1_opcode", bus.opcode, ADD);
            check("t1_op_a",   bus.operand_a, 5);
            check("t1_op_b",   bus.operand_b, 7);
            if (j == 2) bus.req0_valid = 1'b0;
        end
        step();
        check("t1_load_off",   bus.load_en, 0);
        check("t1_ready_off",  bus.req0_ready, 0);
        check("t1_hold_opc",   bus.opcode, ADD);
        check("t1_hold_op_a",  bus.operand_a, 5);

        // ---------------- both valid, runs of 4 ----------------
        do_reset();
        bus.req0_opcode    = SUB;
        bus.req0_operand_a = 32'sd100;
        bus.req0_operand_b = 32'sd1;
        bus.req1_opcode    = MULT;
        bus.req1_operand_a = -32'sd200;
        bus.req1_operand_b = 32'sd3;
        bus.req0_valid     = 1'b1;
        bus.req1_valid     = 1'b1;
        step();
        check("t2_ready0", bus.req0_ready, 1);
        check("t2_ready1", bus.req1_ready, 0);
        for (int j = 0; j < 12; j++) begin
            bit own1;
            own1 = ((j / 4) % 2) == 1;
            step();
            check("t2_load",   bus.load_en, 1);
            check("t2_index",  bus.write_index, 64'(j));
            check("t2_opcode", bus.opcode, own1 ? MULT : SUB);
            check("t2_op_a",   bus.operand_a, own1 ? -200 : 100);
            check("t2_last_grant", last_grant, 64'(((j + 1) / 4) % 2));
            if (j == 11) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        step();
        check("t2_load_off", bus.load_en, 0);

        // ---------------- 34 writes, pointer wrap ----------------
        do_reset();
        bus.req1_opcode    = DIV;
        bus.req1_operand_a = 32'sd9;
        bus.req1_operand_b = 32'sd2;
        bus.req1_valid     = 1'b1;
        step();
        check("t3_ready1", bus.req1_ready, 1);
        for (int j = 0; j < 34; j++) begin
            step();
            check("t3_load",  bus.load_en, 1);
            check("t3_index", bus.write_index, 64'(j % 32));
            if (j == 33) bus.req1_valid = 1'b0;
        end
        check("t3_last_grant", last_grant, 1);
        step();
        check("t3_load_off", bus.load_en, 0);

        // ---------------- wr_ptr_clr with transfer at slot 9 ----------------
        do_reset();
        bus.req0_opcode = MOD;
        bus.req0_valid  = 1'b1;
        step();
        for (int j = 0; j < 12; j++) begin
            step();
            check("t4_load",  bus.load_en, 1);
            check("t4_index", bus.write_index, 64'((j <= 9) ? j : j - 10));
            if (j == 8)  wr_ptr_clr = 1'b1;
            if (j == 9)  wr_ptr_clr = 1'b0;
            if (j == 11) bus.req0_valid = 1'b0;
        end
        step();
        check("t4_load_off", bus.load_en, 0);

        // ---------------- reset during an OWN1 burst ----------------
        bus.req1_opcode    = PASSA;
        bus.req1_operand_a = 32'sd11;
        bus.req1_operand_b = 32'sd22;
        bus.req1_valid     = 1'b1;
        step();
        check("t5_ready1", bus.req1_ready, 1);
        step();
        check("t5_load",   bus.load_en, 1);
        check("t5_opcode", bus.opcode, PASSA);
        reset_en = 1'b0;
        step();
        check("t5_rst_load",   bus.load_en, 0);
        check("t5_rst_ready0", bus.req0_ready, 0);
        check("t5_rst_ready1", bus.req1_ready, 0);
        check("t5_rst_index",  bus.write_index, 0);
        check("t5_rst_opcode", bus.opcode, ZERO);
        check("t5_rst_op_a",   bus.operand_a, 0);
        check("t5_rst_op_b",   bus.operand_b, 0);
        check("t5_rst_last_grant", last_grant, 1);
        reset_en = 1'b1;
        step();
        check("t5_post_load",   bus.load_en, 0);
        check("t5_post_ready1", bus.req1_ready, 1);
        bus.req1_valid = 1'b0;
        step();

`ifdef IWA_STATS_EN
        // ---------------- grant counters ----------------
        do_reset();
        check("t6_cnt0_rst", grant_cnt0, 0);
        check("t6_cnt1_rst", grant_cnt1, 0);
        bus.req0_valid = 1'b1;
        step();
        for (int j = 0; j < 10; j++) step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        step();
        for (int j = 0; j < 6; j++) step();
        bus.req1_valid = 1'b0;
        step();
        check("t6_cnt0", grant_cnt0, 10);
        check("t6_cnt1", grant_cnt1, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_write_arbiter
